// File: rtl/multi_ctrl_fsm.sv
// Main control FSM for a multicycle MIPS-style CPU: sequences FETCH..WB, decodes the opcode
// and drives the register-file write strobe and datapath selects.
module multi_ctrl_fsm #(
    parameter int unsigned CntW   = 32,
    parameter bit          AddiEn = 1'b1
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic [5:0]      op_i,
    input  logic            zero_i,
    input  logic            mem_ready_i,
    output logic            pc_we_o,
    output logic            iord_o,
    output logic            mem_rd_o,
    output logic            mem_wr_o,
    output logic            ir_we_o,
    output logic            reg_dst_o,
    output logic            mem_to_reg_o,
    output logic            rf_we_o,
    output logic            alu_src_a_o,
    output logic [1:0]      alu_src_b_o,
    output logic [1:0]      alu_op_o,
    output logic [1:0]      pc_src_o,
    output logic [3:0]      state_o,
    output logic            instr_done_o,
    output logic            illegal_o,
    output logic [CntW-1:0] instr_cnt_o
);

    localparam logic [5:0] OpRtype = 6'h00;
    localparam logic [5:0] OpJ     = 6'h02;
    localparam logic [5:0] OpBeq   = 6'h04;
    localparam logic [5:0] OpAddi  = 6'h08;
    localparam logic [5:0] OpLw    = 6'h23;
    localparam logic [5:0] OpSw    = 6'h2B;

    typedef enum logic [3:0] {
        StFetch  = 4'd0,
        StDecode = 4'd1,
        StMemadr = 4'd2,
        StMemrd  = 4'd3,
        StMemwb  = 4'd4,
        StMemwr  = 4'd5,
        StExec   = 4'd6,
        StAluwb  = 4'd7,
        StBranch = 4'd8,
        StAddiex = 4'd9,
        StAddiwb = 4'd10,
        StJump   = 4'd11
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d      = StFetch;
        pc_we_o      = 1'b0;
        iord_o       = 1'b0;
        mem_rd_o     = 1'b0;
        mem_wr_o     = 1'b0;
        ir_we_o      = 1'b0;
        reg_dst_o    = 1'b0;
        mem_to_reg_o = 1'b0;
        rf_we_o      = 1'b0;
        alu_src_a_o  = 1'b0;
        alu_src_b_o  = 2'b00;
        alu_op_o     = 2'b00;
        pc_src_o     = 2'b00;
        instr_done_o = 1'b0;
        illegal_o    = 1'b0;
        case (state_q)
            StFetch: begin
                mem_rd_o    = 1'b1;
                alu_src_b_o = 2'b01;
                pc_we_o     = mem_ready_i;
                ir_we_o     = mem_ready_i;
                state_d     = mem_ready_i ? StDecode : StFetch;
            end
            StDecode: begin
                alu_src_b_o = 2'b11;
                case (op_i)
                    OpRtype:    state_d = StExec;
                    OpLw, OpSw: state_d = StMemadr;
                    OpBeq:      state_d = StBranch;
                    OpJ:        state_d = StJump;
                    OpAddi: begin
                        if (AddiEn) state_d = StAddiex;
                        else        illegal_o = 1'b1;
                    end
                    default:    illegal_o = 1'b1;
                endcase
            end
            StMemadr: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = (op_i == OpSw) ? StMemwr : StMemrd;
            end
            StMemrd: begin
                mem_rd_o = 1'b1;
                iord_o   = 1'b1;
                state_d  = mem_ready_i ? StMemwb : StMemrd;
            end
            StMemwb: begin
                rf_we_o      = 1'b1;
                mem_to_reg_o = 1'b1;
                instr_done_o = 1'b1;
            end
            StMemwr: begin
                mem_wr_o     = 1'b1;
                iord_o       = 1'b1;
                instr_done_o = mem_ready_i;
                state_d      = mem_ready_i ? StFetch : StMemwr;
            end
            StExec: begin
                alu_src_a_o = 1'b1;
                alu_op_o    = 2'b10;
                state_d     = StAluwb;
            end
            StAluwb: begin
                rf_we_o      = 1'b1;
                reg_dst_o    = 1'b1;
                instr_done_o = 1'b1;
            end
            StBranch: begin
                alu_src_a_o  = 1'b1;
                alu_op_o     = 2'b01;
                pc_src_o     = 2'b01;
                pc_we_o      = zero_i;
                instr_done_o = 1'b1;
            end
            StAddiex: begin
                alu_src_a_o = 1'b1;
                alu_src_b_o = 2'b10;
                state_d     = StAddiwb;
            end
            StAddiwb: begin
                rf_we_o      = 1'b1;
                instr_done_o = 1'b1;
            end
            StJump: begin
                pc_src_o     = 2'b10;
                pc_we_o      = 1'b1;
                instr_done_o = 1'b1;
            end
            default: state_d = StFetch;
        endcase

        // Reset aborts the current instruction: no strobe may escape this cycle.
        if (rst_i) begin
            pc_we_o      = 1'b0;
            iord_o       = 1'b0;
            mem_rd_o     = 1'b0;
            mem_wr_o     = 1'b0;
            ir_we_o      = 1'b0;
            reg_dst_o    = 1'b0;
            mem_to_reg_o = 1'b0;
            rf_we_o      = 1'b0;
            alu_src_a_o  = 1'b0;
            alu_src_b_o  = 2'b00;
            alu_op_o     = 2'b00;
            pc_src_o     = 2'b00;
            instr_done_o = 1'b0;
            illegal_o    = 1'b0;
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (instr_done_o) cnt_d = cnt_q + CntW'(1);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StFetch;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign state_o     = state_q;
    assign instr_cnt_o = cnt_q;

endmodule

// File: tb/tb_multi_ctrl_fsm.sv
// Bench for multi_ctrl_fsm: per-instruction state sequences plus a per-state output table from
// the control-word rules, checked every cycle on two configurations.
module tb_multi_ctrl_fsm;

    localparam int StFetch  = 0;
    localparam int StDecode = 1;
    localparam int StMemadr = 2;
    localparam int StMemrd  = 3;
    localparam int StMemwb  = 4;
    localparam int StMemwr  = 5;
    localparam int StExec   = 6;
    localparam int StAluwb  = 7;
    localparam int StBranch = 8;
    localparam int StAddiex = 9;
    localparam int StAddiwb = 10;
    localparam int StJump   = 11;

    typedef struct packed {
        logic       pc_we;
        logic       iord;
        logic       mem_rd;
        logic       mem_wr;
        logic       ir_we;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       rf_we;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [1:0] pc_src;
        logic       instr_done;
        logic       illegal;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       rst_a, rst_b;
    logic [5:0] op;
    logic       zero, mem_ready;

    ctrl_t       got_a, got_b;
    logic [3:0]  st_a, st_b;
    logic [31:0] cnt_a;
    logic [3:0]  cnt_b;

    int          checks = 0;
    int          errors = 0;
    ctrl_t       exp_w   [2];
    int          exp_st  [2];
    int unsigned exp_cnt [2];
    int unsigned mcnt    [2];
    bit          chk_en  [2];
    bit          exp_rst [2];
    int          ill_cnt [2];

    always #5 clk = ~clk;

    multi_ctrl_fsm u_a (
        .clk_i        (clk),
        .rst_i        (rst_a),
        .op_i         (op),
        .zero_i       (zero),
        .mem_ready_i  (mem_ready),
        .pc_we_o      (got_a.pc_we),
        .iord_o       (got_a.iord),
        .mem_rd_o     (got_a.mem_rd),
        .mem_wr_o     (got_a.mem_wr),
        .ir_we_o      (got_a.ir_we),
        .reg_dst_o    (got_a.reg_dst),
        .mem_to_reg_o (got_a.mem_to_reg),
        .rf_we_o      (got_a.rf_we),
        .alu_src_a_o  (got_a.alu_src_a),
        .alu_src_b_o  (got_a.alu_src_b),
        .alu_op_o     (got_a.alu_op),
        .pc_src_o     (got_a.pc_src),
        .state_o      (st_a),
        .instr_done_o (got_a.instr_done),
        .illegal_o    (got_a.illegal),
        .instr_cnt_o  (cnt_a)
    );

    multi_ctrl_fsm #(
        .CntW   (4),
        .AddiEn (1'b0)
    ) u_b (
        .clk_i        (clk),
        .rst_i        (rst_b),
        .op_i         (op),
        .zero_i       (zero),
        .mem_ready_i  (mem_ready),
        .pc_we_o      (got_b.pc_we),
        .iord_o       (got_b.iord),
        .mem_rd_o     (got_b.mem_rd),
        .mem_wr_o     (got_b.mem_wr),
        .ir_we_o      (got_b.ir_we),
        .reg_dst_o    (got_b.reg_dst),
        .mem_to_reg_o (got_b.mem_to_reg),
        .rf_we_o      (got_b.rf_we),
        .alu_src_a_o  (got_b.alu_src_a),
        .alu_src_b_o  (got_b.alu_src_b),
        .alu_op_o     (got_b.alu_op),
        .pc_src_o     (got_b.pc_src),
        .state_o      (st_b),
        .instr_done_o (got_b.instr_done),
        .illegal_o    (got_b.illegal),
        .instr_cnt_o  (cnt_b)
    );

    function automatic ctrl_t ctrl_word(input int st, input logic [5:0] o, input logic z,
                                        input logic mr, input bit addi_ok);
        ctrl_t w = '0;
        case (st)
            StFetch:  begin w.mem_rd = 1; w.alu_src_b = 2'b01; w.pc_we = mr; w.ir_we = mr; end
            StDecode: begin
                w.alu_src_b = 2'b11;
                w.illegal = !(o == 6'h00 || o == 6'h23 || o == 6'h2B || o == 6'h04 ||
                              o == 6'h02 || (o == 6'h08 && addi_ok));
            end
            StMemadr: begin w.alu_src_a = 1; w.alu_src_b = 2'b10; end
            StMemrd:  begin w.mem_rd = 1; w.iord = 1; end
            StMemwb:  begin w.rf_we = 1; w.mem_to_reg = 1; w.instr_done = 1; end
            StMemwr:  begin w.mem_wr = 1; w.iord = 1; w.instr_done = mr; end
            StExec:   begin w.alu_src_a = 1; w.alu_op = 2'b10; end
            StAluwb:  begin w.rf_we = 1; w.reg_dst = 1; w.instr_done = 1; end
            StBranch: begin
                w.alu_src_a = 1; w.alu_op = 2'b01; w.pc_src = 2'b01; w.pc_we = z;
                w.instr_done = 1;
            end
            StAddiex: begin w.alu_src_a = 1; w.alu_src_b = 2'b10; end
            StAddiwb: begin w.rf_we = 1; w.instr_done = 1; end
            StJump:   begin w.pc_src = 2'b10; w.pc_we = 1; w.instr_done = 1; end
            default:  w = '0;
        endcase
        return w;
    endfunction

    function automatic ctrl_t strobe_mask();
        ctrl_t m = '0;
        m.pc_we = 1; m.mem_rd = 1; m.mem_wr = 1; m.ir_we = 1; m.rf_we = 1;
        m.instr_done = 1; m.illegal = 1;
        return m;
    endfunction

    always @(negedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (chk_en[s]) begin
                ctrl_t       g, m;
                int          gs;
                int unsigned gc;
                g  = (s == 0) ? got_a : got_b;
                gs = (s == 0) ? int'(st_a) : int'(st_b);
                gc = (s == 0) ? cnt_a : {28'd0, cnt_b};
                m  = exp_rst[s] ? strobe_mask() : '1;
                ill_cnt[s] += (g.illegal === 1'b1) ? 1 : 0;
                checks++;
                if ((g & m) !== (exp_w[s] & m)) begin
                    errors++;
                    $display("FAIL ctrl dut%0d st%0d t=%0t: got %h required %h", s, exp_st[s],
                             $time, g & m, exp_w[s] & m);
                end
                checks++;
                if (gs != exp_st[s]) begin
                    errors++;
                    $display("FAIL state dut%0d t=%0t: got %0d required %0d", s, $time, gs,
                             exp_st[s]);
                end
                checks++;
                if (gc != exp_cnt[s]) begin
                    errors++;
                    $display("FAIL instr_cnt dut%0d t=%0t: got %0d required %0d", s, $time, gc,
                             exp_cnt[s]);
                end
            end
        end
    end

    // One clock cycle: drive inputs just after the edge, publish expectations, advance model.
    task automatic cyc(input int sel, input int st, input logic [5:0] o, input logic z,
                       input logic mr, input logic r);
        op = o; zero = z; mem_ready = mr;
        if (sel == 0) rst_a = r; else rst_b = r;
        exp_st[sel]  = st;
        exp_rst[sel] = r;
        exp_w[sel]   = r ? ctrl_t'(0) : ctrl_word(st, o, z, mr, sel == 0);
        exp_cnt[sel] = mcnt[sel];
        chk_en[sel]  = 1'b1;
        @(posedge clk);
        #1;
        if (r) mcnt[sel] = 0;
        else if (exp_w[sel].instr_done) mcnt[sel] = (mcnt[sel] + 1) & ((sel == 0) ? 32'hFFFF_FFFF : 32'hF);
    endtask

    task automatic instr(input int sel, input logic [5:0] o, input logic z, input int fw,
                         input int mw, output int n);
        int seq[$];
        n = 0;
        for (int i = 0; i < fw; i++) begin cyc(sel, StFetch, o, z, 1'b0, 1'b0); n++; end
        cyc(sel, StFetch, o, z, 1'b1, 1'b0); n++;
        cyc(sel, StDecode, o, z, 1'b1, 1'b0); n++;
        case (o)
            6'h00:   seq = '{StExec, StAluwb};
            6'h23:   seq = '{StMemadr, StMemrd, StMemwb};
            6'h2B:   seq = '{StMemadr, StMemwr};
            6'h04:   seq = '{StBranch};
            6'h02:   seq = '{StJump};
            6'h08:   if (sel == 0) seq = '{StAddiex, StAddiwb};
            default: seq = {};
        endcase
        foreach (seq[k]) begin
            if (seq[k] == StMemrd || seq[k] == StMemwr) begin
                for (int i = 0; i < mw; i++) begin cyc(sel, seq[k], o, z, 1'b0, 1'b0); n++; end
            end
            cyc(sel, seq[k], o, z, 1'b1, 1'b0); n++;
        end
    endtask

    task automatic lit(input string name, input longint got, input longint req);
        checks++;
        if (got != req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    initial begin
        int n;
        rst_a = 1; rst_b = 1; op = '0; zero = 0; mem_ready = 0;
        for (int s = 0; s < 2; s++) begin
            chk_en[s] = 0; mcnt[s] = 0; ill_cnt[s] = 0; exp_rst[s] = 1;
            exp_st[s] = 0; exp_cnt[s] = 0; exp_w[s] = '0;
        end
        @(posedge clk);
        #1;
        cyc(0, StFetch, 6'h00, 1'b0, 1'b1, 1'b1);

        // R-type, lw with two memory stalls, beq not taken / taken
        instr(0, 6'h00, 1'b0, 0, 0, n); lit("r_latency", n, 4); lit("r_cnt", cnt_a, 1);
        instr(0, 6'h23, 1'b0, 0, 2, n); lit("lw_latency", n, 7); lit("lw_cnt", cnt_a, 2);
        instr(0, 6'h04, 1'b0, 0, 0, n); lit("beq0_latency", n, 3);
        instr(0, 6'h04, 1'b1, 0, 0, n); lit("beq1_latency", n, 3); lit("beq_cnt", cnt_a, 4);

        // sw with a fetch stall and a write stall, addi, jump
        instr(0, 6'h2B, 1'b0, 1, 1, n); lit("sw_latency", n, 6);
        instr(0, 6'h08, 1'b0, 0, 0, n); lit("addi_latency", n, 4);
        instr(0, 6'h02, 1'b0, 0, 0, n); lit("j_latency", n, 3); lit("cnt_after_j", cnt_a, 7);

        // Illegal opcode: one pulse, back to FETCH, not counted
        instr(0, 6'h3F, 1'b0, 0, 0, n); lit("ill_latency", n, 2);
        lit("ill_pulses", ill_cnt[0], 1); lit("ill_cnt", cnt_a, 7);

        // Reset landing in MEMWB aborts the load
        cyc(0, StFetch,  6'h23, 1'b0, 1'b1, 1'b0);
        cyc(0, StDecode, 6'h23, 1'b0, 1'b1, 1'b0);
        cyc(0, StMemadr, 6'h23, 1'b0, 1'b1, 1'b0);
        cyc(0, StMemrd,  6'h23, 1'b0, 1'b1, 1'b0);
        cyc(0, StMemwb,  6'h23, 1'b0, 1'b1, 1'b1);
        lit("rst_state", st_a, 0); lit("rst_cnt", cnt_a, 0);
        instr(0, 6'h00, 1'b0, 0, 0, n); lit("post_rst_cnt", cnt_a, 1);

        // Second configuration: addi disabled, 4-bit counter
        chk_en[0] = 0; rst_a = 1;
        instr(1, 6'h08, 1'b0, 0, 0, n); lit("b_addi_latency", n, 2);
        lit("b_ill_pulses", ill_cnt[1], 1); lit("b_ill_cnt", cnt_b, 0);
        for (int i = 0; i < 15; i++) instr(1, 6'h02, 1'b0, 0, 0, n);
        lit("b_cnt15", cnt_b, 15);
        instr(1, 6'h02, 1'b0, 0, 0, n); lit("b_wrap", cnt_b, 0);

        chk_en[1] = 0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
